// File: rtl/se_drain_if.sv
// Drain-unit bus: controller-side accumulator/command inputs and the serial
// element stream that the drain unit produces.
interface se_drain_if #(
  parameter int P     = 4,
  parameter int ACC_W = 40
);
  logic [P*P*ACC_W-1:0]    acc_flat;
  logic                    acc_clr;
  logic                    out_phase;
  logic                    se_valid;
  logic signed [ACC_W-1:0] se_c;
  logic [3:0]              se_idx;
  logic                    busy;
  logic                    drain_done;

  modport master (
    output acc_flat, acc_clr, out_phase,
    input  se_valid, se_c, se_idx, busy, drain_done
  );

  modport slave (
    input  acc_flat, acc_clr, out_phase,
    output se_valid, se_c, se_idx, busy, drain_done
  );
endinterface

// File: rtl/se_drain_unit.sv
// Snapshots the PxP PE accumulators and streams them out row-major, one
// element per cycle, with abort on accumulator clear and a HOLD interlock.
module se_drain_unit #(
  parameter int P     = 4,
  parameter int ACC_W = 40
) (
  input logic      clk,
  input logic      rst,
  se_drain_if.slave bus
);

  localparam int         N    = P * P;
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, HOLD} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              cnt;
  logic [3:0]              cnt_inc;
  logic signed [ACC_W-1:0] snap [N];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_inc    = cnt + 4'd1;
    case (state)
      IDLE:    if (bus.out_phase && !bus.acc_clr) state_next = CAPTURE;
      CAPTURE: state_next = bus.acc_clr ? IDLE : SHIFT;
      SHIFT: begin
        if (bus.acc_clr)      state_next = IDLE;
        else if (cnt == LAST) state_next = HOLD;
      end
      HOLD:    if (!bus.out_phase) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot is deliberately not reset; it is only visible through se_c while se_valid is high.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      for (int e = 0; e < N; e++) begin
        snap[e] <= bus.acc_flat[e*ACC_W +: ACC_W];
      end
    end
  end

  // Element 0 is taken straight from acc_flat on the capture edge so the
  // first beat appears in the first SHIFT cycle; se_c holds when not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= 4'd0;
      bus.se_valid   <= 1'b0;
      bus.se_c       <= '0;
      bus.se_idx     <= 4'd0;
      bus.busy       <= 1'b0;
      bus.drain_done <= 1'b0;
    end else begin
      bus.busy       <= (state_next == CAPTURE) || (state_next == SHIFT);
      bus.drain_done <= (state == SHIFT) && (state_next == HOLD);
      bus.se_valid   <= 1'b0;
      bus.se_idx     <= 4'd0;
      case (state)
        CAPTURE: begin
          cnt <= 4'd0;
          if (state_next == SHIFT) begin
            bus.se_valid <= 1'b1;
            bus.se_c     <= bus.acc_flat[ACC_W-1:0];
          end
        end
        SHIFT: begin
          if (state_next == SHIFT) begin
            cnt          <= cnt_inc;
            bus.se_valid <= 1'b1;
            bus.se_c     <= snap[cnt_inc];
            bus.se_idx   <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
